// File: rtl/conv_ctrl_pkg.sv
// Shared types and defaults for the convolution run controller.
// The state encoding is visible to checkers through conv_run_ctrl.state_dbg.
package conv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_K_PF,
    ST_K_LOAD,
    ST_SETTLE,
    ST_IF_GO,
    ST_RUN,
    ST_GAP,
    ST_FIN,
    ST_ERR
  } conv_ctrl_state_t;

  localparam int DEF_SETTLE = 100;
  localparam int DEF_GAP    = 100;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_ctrl_beat_cnt.sv
// Saturating per-kernel beat counter.
// The full output reflects this cycle's increment, so the controller can leave K_LOAD on the last beat.
module conv_ctrl_beat_cnt #(
  parameter int K_BEATS = 27,
  localparam int CW = $clog2(K_BEATS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic full
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_nxt;

  // A clear and a beat in the same cycle leave a count of one.
  always_comb begin
    cnt_base = clr ? '0 : cnt;
    cnt_nxt  = cnt_base;
    if (inc && (cnt_base != CW'(K_BEATS))) begin
      cnt_nxt = cnt_base + 1'b1;
    end
  end

  assign full = (cnt_nxt == CW'(K_BEATS));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/conv_run_ctrl.sv
// Run-level sequencer: kernel prefetch, load tracking, settle, frame start,
// frame completion and inter-iteration gap, with watchdog and abort.
module conv_run_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int K_NUM         = 3,
  parameter int K_BEATS       = 27,
  parameter int SETTLE_CYCLES = DEF_SETTLE,
  parameter int GAP_CYCLES    = DEF_GAP,
  parameter int ITER_W        = 8,
  parameter int TMO_W         = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [ITER_W-1:0] cmd_num_iter,
  input  logic              cmd_abort,
  input  logic [K_NUM-1:0]  k_i_valid,
  input  logic              of_done,
  output logic              k_prefetch,
  output logic              if_start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [ITER_W-1:0] iter_idx,
  output conv_ctrl_state_t  state_dbg
);

  localparam int PH_W = $clog2(max2(SETTLE_CYCLES, GAP_CYCLES) + 1);
  // Expiry is taken on the step into all-ones, so the flag rises 2**TMO_W-1 cycles after entry.
  localparam logic [TMO_W-1:0] WD_LAST = ~TMO_W'(1);

  conv_ctrl_state_t  state, state_nxt;
  logic [K_NUM-1:0]  k_full;
  logic              cnt_clr, cnt_en;
  logic [PH_W-1:0]   ph_cnt;
  logic [TMO_W-1:0]  wd;
  logic [ITER_W-1:0] n_iter;
  logic              settle_end, gap_end, wd_hit, last_iter;

  assign cnt_clr = (state == ST_K_PF);
  assign cnt_en  = (state == ST_K_PF) || (state == ST_K_LOAD);

  for (genvar g = 0; g < K_NUM; g++) begin : g_beat
    conv_ctrl_beat_cnt #(.K_BEATS(K_BEATS)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_en & k_i_valid[g]),
      .full (k_full[g])
    );
  end

  assign settle_end = (ph_cnt == PH_W'(SETTLE_CYCLES - 1));
  assign gap_end    = (ph_cnt == PH_W'(GAP_CYCLES - 1));
  assign wd_hit     = (wd == WD_LAST);
  assign last_iter  = (iter_idx == (n_iter - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks every other transition, including a coincident of_done or start.
  always_comb begin
    state_nxt = state;
    if (cmd_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (cmd_start) state_nxt = (cmd_num_iter == '0) ? ST_FIN : ST_K_PF;
        ST_K_PF:   state_nxt = ST_K_LOAD;
        ST_K_LOAD: if (&k_full) state_nxt = ST_SETTLE;
                   else if (wd_hit) state_nxt = ST_ERR;
        ST_SETTLE: if (settle_end) state_nxt = ST_IF_GO;
        ST_IF_GO:  state_nxt = ST_RUN;
        ST_RUN:    if (of_done) state_nxt = ST_GAP;
                   else if (wd_hit) state_nxt = ST_ERR;
        ST_GAP:    if (gap_end) state_nxt = last_iter ? ST_FIN : ST_K_PF;
        ST_FIN:    state_nxt = ST_IDLE;
        ST_ERR:    state_nxt = ST_ERR;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt      <= '0;
      wd          <= '0;
      n_iter      <= '0;
      iter_idx    <= '0;
      err_timeout <= 1'b0;
    end else begin
      ph_cnt <= ((state == ST_SETTLE || state == ST_GAP) && state_nxt == state) ?
                ph_cnt + 1'b1 : '0;
      wd     <= (state == ST_K_LOAD || state == ST_RUN) ? wd + 1'b1 : '0;
      if (state == ST_IDLE && cmd_start && !cmd_abort) begin
        n_iter <= cmd_num_iter;
      end
      if (cmd_abort || state == ST_FIN || state == ST_IDLE) begin
        iter_idx <= '0;
      end else if (state == ST_GAP && gap_end && !last_iter) begin
        iter_idx <= iter_idx + 1'b1;
      end
      if (cmd_abort) begin
        err_timeout <= 1'b0;
      end else if (state_nxt == ST_ERR && state != ST_ERR) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Pulses decode the state register only, so no input reaches them combinationally.
  assign k_prefetch = (state == ST_K_PF);
  assign if_start   = (state == ST_IF_GO);
  assign done       = (state == ST_FIN);
  assign busy       = (state != ST_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_conv_run_ctrl.sv
// Directed bench for conv_run_ctrl: default instance plus an 8-bit watchdog instance
// sharing the same stimulus; cycle numbers below are hand-derived from the behaviour.
module tb_conv_run_ctrl;
  import conv_ctrl_pkg::*;

  localparam int ITER_W = 8;
  localparam int SETTLE = 100;
  localparam int GAP    = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_start = 1'b0;
  logic [ITER_W-1:0] cmd_num_iter = '0;
  logic              cmd_abort = 1'b0;
  logic [2:0]        k_i_valid = '0;
  logic              of_done = 1'b0;

  logic k_prefetch, if_start, busy, done, err_timeout;
  logic [ITER_W-1:0] iter_idx;
  conv_ctrl_state_t  state_dbg;

  logic wd_k_prefetch, wd_if_start, wd_busy, wd_done, wd_err_timeout;
  logic [ITER_W-1:0] wd_iter_idx;
  conv_ctrl_state_t  wd_state_dbg;

  conv_run_ctrl u_dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_num_iter(cmd_num_iter),
    .cmd_abort(cmd_abort), .k_i_valid(k_i_valid), .of_done(of_done),
    .k_prefetch(k_prefetch), .if_start(if_start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .iter_idx(iter_idx), .state_dbg(state_dbg)
  );

  conv_run_ctrl #(.TMO_W(8)) u_wd (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_num_iter(cmd_num_iter),
    .cmd_abort(cmd_abort), .k_i_valid(k_i_valid), .of_done(of_done),
    .k_prefetch(wd_k_prefetch), .if_start(wd_if_start), .busy(wd_busy), .done(wd_done),
    .err_timeout(wd_err_timeout), .iter_idx(wd_iter_idx), .state_dbg(wd_state_dbg)
  );

  // Clock and cycle index: "cycle n" is the interval after the n-th rising edge.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int n_kpf = 0, n_ifs = 0, n_done = 0, n_wd_ifs = 0;
  int t_settle = -1;
  conv_ctrl_state_t prev_state = ST_IDLE;
  logic [ITER_W-1:0] exp_q[$];
  logic [ITER_W-1:0] got_q[$];

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (k_prefetch) begin
      n_kpf++;
      got_q.push_back(iter_idx);
    end
    if (if_start) n_ifs++;
    if (done) n_done++;
    if (wd_if_start) n_wd_ifs++;
    if (state_dbg == ST_SETTLE && prev_state != ST_SETTLE) t_settle = cyc;
    prev_state = state_dbg;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return k_prefetch;
      1: return if_start;
      2: return done;
      3: return wd_err_timeout;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, input string tag, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sel(which)) begin
        t = cyc;
        break;
      end
    end
    n_checks++;
    assert (t >= 0) else begin
      n_fail++;
      $error("FAIL %s: got no pulse expected one within %0d cycles", tag, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; of_done = 1'b0; k_i_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Returns in the cycle where the controller sits in K_PF.
  task automatic start_run(input int n);
    cmd_num_iter = ITER_W'(n);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  // Kernel i sends n_i beats in cycles P+d_i .. P+d_i+n_i-1, P being the call cycle.
  task automatic feed(input int n0, input int n1, input int n2,
                      input int d0, input int d1, input int d2);
    int n[3];
    int d[3];
    int last;
    n[0] = n0; n[1] = n1; n[2] = n2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    last = 0;
    for (int i = 0; i < 3; i++) if (d[i] + n[i] - 1 > last) last = d[i] + n[i] - 1;
    for (int c = 1; c <= last; c++) begin
      step();
      for (int i = 0; i < 3; i++) k_i_valid[i] = (c >= d[i]) && (c < d[i] + n[i]);
    end
    step();
    k_i_valid = '0;
  endtask

  task automatic pulse_of_done();
    of_done = 1'b1;
    step();
    of_done = 1'b0;
  endtask

  int p, r, t, b_kpf, b_ifs, b_done, b_wd;

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_kpf", k_prefetch, 0);
    check("rst_ifs", if_start, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_iter", iter_idx, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    step();

    // Nominal two-iteration run: if_start at Tload+1+SETTLE, next prefetch or done at of_done+1+GAP
    start_run(2);
    p = cyc;
    exp_q.push_back(0);
    check("nom_kpf", k_prefetch, 1);
    check("nom_busy", busy, 1);
    feed(27, 27, 27, 2, 2, 2);
    wait_sig(1, 300, "nom_if0_wait", t);
    check("nom_if0_cyc", t, p + 28 + 1 + SETTLE);
    repeat (500) step();
    r = cyc;
    pulse_of_done();
    wait_sig(0, 300, "nom_kpf1_wait", t);
    check("nom_kpf1_cyc", t, r + 1 + GAP);
    check("nom_iter1", iter_idx, 1);
    exp_q.push_back(1);
    p = t;
    feed(27, 27, 27, 2, 2, 2);
    wait_sig(1, 300, "nom_if1_wait", t);
    check("nom_if1_cyc", t, p + 28 + 1 + SETTLE);
    repeat (500) step();
    r = cyc;
    pulse_of_done();
    wait_sig(2, 300, "nom_done_wait", t);
    check("nom_done_cyc", t, r + 1 + GAP);
    step();
    check("nom_idle_busy", busy, 0);
    check("nom_idle_iter", iter_idx, 0);
    check("nom_n_kpf", n_kpf, 2);
    check("nom_n_ifs", n_ifs, 2);
    check("nom_n_done", n_done, 1);

    // Skewed kernels: kernel2 last beat at P+68 plus five extra beats
    do_reset();
    start_run(1);
    p = cyc;
    exp_q.push_back(0);
    feed(27, 27, 32, 2, 2, 42);
    wait_sig(1, 300, "skew_if_wait", t);
    check("skew_settle_cyc", t_settle, p + 69);
    check("skew_if_cyc", t, p + 69 + SETTLE);
    repeat (50) step();
    r = cyc;
    pulse_of_done();
    wait_sig(2, 300, "skew_done_wait", t);
    check("skew_done_cyc", t, r + 1 + GAP);

    // Zero iterations: done in the cycle after the start, busy for that one cycle
    do_reset();
    b_kpf = n_kpf;
    b_ifs = n_ifs;
    start_run(0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    check("zero_kpf", k_prefetch, 0);
    step();
    check("zero_busy_after", busy, 0);
    check("zero_done_after", done, 0);
    repeat (5) step();
    check("zero_n_kpf", n_kpf, b_kpf);
    check("zero_n_ifs", n_ifs, b_ifs);

    // Watchdog: K_LOAD entered at P+1, flag visible 255 cycles later
    do_reset();
    b_wd = n_wd_ifs;
    start_run(1);
    p = cyc;
    exp_q.push_back(0);
    feed(27, 26, 27, 2, 2, 2);
    wait_sig(3, 400, "tmo_wait", t);
    check("tmo_cyc", t, p + 1 + 255);
    check("tmo_state", wd_state_dbg, ST_ERR);
    repeat (20) step();
    check("tmo_sticky", wd_err_timeout, 1);
    check("tmo_busy", wd_busy, 1);
    check("tmo_no_ifs", n_wd_ifs, b_wd);
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    check("tmo_abort_err", wd_err_timeout, 0);
    check("tmo_abort_busy", wd_busy, 0);

    // Abort coincident with of_done in RUN
    do_reset();
    start_run(2);
    exp_q.push_back(0);
    feed(27, 27, 27, 2, 2, 2);
    wait_sig(1, 300, "abort_if_wait", t);
    repeat (20) step();
    b_kpf = n_kpf;
    b_done = n_done;
    cmd_abort = 1'b1;
    of_done = 1'b1;
    step();
    cmd_abort = 1'b0;
    of_done = 1'b0;
    check("abort_state", state_dbg, ST_IDLE);
    check("abort_iter", iter_idx, 0);
    repeat (150) step();
    check("abort_n_done", n_done, b_done);
    check("abort_n_kpf", n_kpf, b_kpf);

    // Reset in the middle of SETTLE
    do_reset();
    start_run(1);
    exp_q.push_back(0);
    feed(27, 27, 27, 2, 2, 2);
    repeat (30) step();
    check("rst_mid_state", state_dbg, ST_SETTLE);
    b_ifs = n_ifs;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ifs", if_start, 0);
    check("rst_mid_state_after", state_dbg, ST_IDLE);
    repeat (150) step();
    check("rst_mid_n_ifs", n_ifs, b_ifs);

    // Ignored inputs: stray of_done in SETTLE, cmd_start with 5 iterations during RUN
    do_reset();
    start_run(2);
    p = cyc;
    exp_q.push_back(0);
    feed(27, 27, 27, 2, 2, 2);
    repeat (10) step();
    pulse_of_done();
    check("ign_settle_state", state_dbg, ST_SETTLE);
    wait_sig(1, 300, "ign_if0_wait", t);
    check("ign_if0_cyc", t, p + 28 + 1 + SETTLE);
    repeat (5) step();
    cmd_num_iter = 8'd5;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    check("ign_run_state", state_dbg, ST_RUN);
    repeat (44) step();
    r = cyc;
    pulse_of_done();
    wait_sig(0, 300, "ign_kpf1_wait", t);
    check("ign_kpf1_cyc", t, r + 1 + GAP);
    check("ign_iter1", iter_idx, 1);
    exp_q.push_back(1);
    feed(27, 27, 27, 2, 2, 2);
    wait_sig(1, 300, "ign_if1_wait", t);
    repeat (50) step();
    r = cyc;
    b_kpf = n_kpf;
    pulse_of_done();
    wait_sig(2, 300, "ign_done_wait", t);
    check("ign_done_cyc", t, r + 1 + GAP);
    repeat (300) step();
    check("ign_no_more_kpf", n_kpf, b_kpf);
    check("ign_idle", busy, 0);

    // Scoreboard: iteration index seen at every prefetch pulse
    check("iter_q_size", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("iter_q[%0d]", i), got_q[i], exp_q[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
